// File: rtl/branch_resolve_unit_if.sv
// Bundles the ID/EX/MEM hazard inputs and the branch control outputs of branch_resolve_unit.
// Optional statistics outputs exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_unit_if #(
    parameter int REG_AW = 5
);
    logic              id_beq;
    logic              id_bne;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              equal;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              pc_src;
    logic              if_id_flush;
    logic              stall;
    logic              id_ex_bubble;
    logic              busy;
`ifdef BRANCH_STATS_EN
    logic [31:0]       stat_branches;
    logic [31:0]       stat_taken;
    logic [31:0]       stat_stall_cycles;

    modport master (
        output id_beq, id_bne, id_rs, id_rt, equal,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        input  pc_src, if_id_flush, stall, id_ex_bubble, busy,
               stat_branches, stat_taken, stat_stall_cycles
    );

    modport slave (
        input  id_beq, id_bne, id_rs, id_rt, equal,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        output pc_src, if_id_flush, stall, id_ex_bubble, busy,
               stat_branches, stat_taken, stat_stall_cycles
    );
`else
    modport master (
        output id_beq, id_bne, id_rs, id_rt, equal,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        input  pc_src, if_id_flush, stall, id_ex_bubble, busy
    );

    modport slave (
        input  id_beq, id_bne, id_rs, id_rt, equal,
               ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        output pc_src, if_id_flush, stall, id_ex_bubble, busy
    );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution controller: stalls on EX/MEM source hazards, then resolves BEQ/BNE.
// Define BRANCH_STATS_EN to add saturating branch/taken/stall-cycle counters.
module branch_resolve_unit #(
    parameter int REG_AW      = 5,
    parameter int LOAD_STALLS = 2,
    parameter int ALU_STALLS  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_resolve_unit_if.slave    bus
);
    localparam int MAX_STALLS = (LOAD_STALLS > ALU_STALLS) ? LOAD_STALLS : ALU_STALLS;
    localparam int CNT_W      = $clog2(MAX_STALLS + 1);

    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] need;
    logic [CNT_W-1:0] load_need;
    logic [CNT_W-1:0] alu_need;
    logic             br;
    logic             taken;
    logic             ld_hit;
    logic             alu_hit;
    logic             resolve;

    // Register 0 is hard-wired, so a write to it can never create a hazard.
    function automatic logic hit(input logic [REG_AW-1:0] x, input logic [REG_AW-1:0] r);
        return (x == r) && (r != '0);
    endfunction

    assign br    = bus.id_beq | bus.id_bne;
    assign taken = bus.id_beq ? bus.equal : ~bus.equal;

    assign ld_hit  = bus.ex_memread &
                     (hit(bus.id_rs, bus.ex_rd) | hit(bus.id_rt, bus.ex_rd));
    assign alu_hit = (bus.ex_regwrite &
                      (hit(bus.id_rs, bus.ex_rd) | hit(bus.id_rt, bus.ex_rd))) |
                     (bus.mem_memread &
                      (hit(bus.id_rs, bus.mem_rd) | hit(bus.id_rt, bus.mem_rd)));

    assign load_need = ld_hit  ? CNT_W'(LOAD_STALLS) : '0;
    assign alu_need  = alu_hit ? CNT_W'(ALU_STALLS)  : '0;
    assign need      = (load_need > alu_need) ? load_need : alu_need;

    // NOTE: every output gets a default before the case so no path leaves one unassigned
    // (which would infer a latch); the rst_n gate forces all outputs low during reset.
    always_comb begin
        bus.pc_src       = 1'b0;
        bus.if_id_flush  = 1'b0;
        bus.stall        = 1'b0;
        bus.id_ex_bubble = 1'b0;
        resolve          = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (br && need == '0) begin
                        bus.pc_src      = taken;
                        bus.if_id_flush = taken;
                        resolve         = 1'b1;
                    end else if (br) begin
                        bus.stall        = 1'b1;
                        bus.id_ex_bubble = 1'b1;
                    end
                end
                STALL: begin
                    bus.stall        = 1'b1;
                    bus.id_ex_bubble = 1'b1;
                end
                RESOLVE: begin
                    bus.pc_src      = taken;
                    bus.if_id_flush = taken;
                    resolve         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = rst_n && (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (br && need != '0) begin
                        if (need == CNT_W'(1)) begin
                            state <= RESOLVE;
                        end else begin
                            cnt   <= need - 1'b1;
                            state <= STALL;
                        end
                    end
                end
                STALL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= RESOLVE;
                end
                RESOLVE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] taken_q;
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branches_q     <= '0;
            taken_q        <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (resolve && branches_q != '1)              branches_q     <= branches_q + 32'd1;
            if (resolve && taken && taken_q != '1)        taken_q        <= taken_q + 32'd1;
            if (bus.stall && stall_cycles_q != '1)        stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign bus.stat_branches     = branches_q;
    assign bus.stat_taken        = taken_q;
    assign bus.stat_stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of branch/hazard vectors plus reset corner sequences.
module tb_branch_resolve_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_resolve_unit_if #(.REG_AW(5)) bus ();

    branch_resolve_unit #(
        .REG_AW(5), .LOAD_STALLS(2), .ALU_STALLS(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       beq;
        logic       bne;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       eq;
        logic       ex_wr;
        logic       ex_ld;
        logic [4:0] ex_rd;
        logic       mem_ld;
        logic [4:0] mem_rd;
        int         stalls;
        logic       taken;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {pc_src, if_id_flush, stall, id_ex_bubble, busy}
    function automatic logic [4:0] outs();
        return {bus.pc_src, bus.if_id_flush, bus.stall, bus.id_ex_bubble, bus.busy};
    endfunction

    task automatic drive(input vec_t v);
        bus.id_beq      = v.beq;
        bus.id_bne      = v.bne;
        bus.id_rs       = v.rs;
        bus.id_rt       = v.rt;
        bus.equal       = v.eq;
        bus.ex_regwrite = v.ex_wr;
        bus.ex_memread  = v.ex_ld;
        bus.ex_rd       = v.ex_rd;
        bus.mem_memread = v.mem_ld;
        bus.mem_rd      = v.mem_rd;
    endtask

    task automatic drive_idle();
        vec_t z;
        z = '{"idle", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 0, 1'b0};
        drive(z);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{"beq_nohaz",   1, 0,  3,  4, 1, 0, 0,  0, 0,  0, 0, 1};
        vecs[1]  = '{"bne_eq",      0, 1,  3,  4, 1, 0, 0,  0, 0,  0, 0, 0};
        vecs[2]  = '{"ld_ex_rs",    1, 0,  5,  6, 1, 1, 1,  5, 0,  0, 2, 1};
        vecs[3]  = '{"alu_ex_rt",   0, 1,  2,  7, 0, 1, 0,  7, 0,  0, 1, 1};
        vecs[4]  = '{"zero_reg",    1, 0,  0,  0, 1, 1, 1,  0, 0,  0, 0, 1};
        vecs[5]  = '{"ld_plus_mem", 1, 0,  8,  9, 0, 1, 1,  8, 1,  9, 2, 0};
        vecs[6]  = '{"mem_ld_rt",   0, 1,  4, 10, 1, 0, 0,  0, 1, 10, 1, 0};
        vecs[7]  = '{"alu_and_mem", 1, 0, 11, 12, 1, 1, 0, 12, 1, 11, 1, 1};
        vecs[8]  = '{"no_branch",   0, 0,  5,  5, 1, 1, 1,  5, 1,  5, 0, 0};
        vecs[9]  = '{"no_regwrite", 0, 1, 13, 14, 0, 0, 0, 13, 0,  0, 0, 1};
        vecs[10] = '{"ld_miss",     1, 0, 15, 16, 0, 1, 1, 17, 1, 18, 0, 0};
        vecs[11] = '{"ld_ex_rt_ne", 1, 0, 20, 21, 0, 1, 1, 21, 0,  0, 2, 0};

        // Reset held with a resolvable BEQ on the inputs: everything must stay low.
        rst_n = 1'b0;
        drive_idle();
        bus.id_beq = 1'b1;
        bus.equal  = 1'b1;
        repeat (2) next_cycle();
        #2;
        check("reset_outs", 32'(outs()), 32'(5'b00000));
        rst_n = 1'b1;
        #1;
        check("post_reset_resolve", 32'(outs()), 32'(5'b11000));
        next_cycle();
        drive_idle();

        // Fresh reset so the statistics start from zero before the table.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            for (int c = 0; c < vecs[i].stalls; c++) begin
                #2;
                check($sformatf("%s_stall%0d", vecs[i].name, c), 32'(outs()),
                      32'({3'b001, 1'b1, (c > 0)}));
                next_cycle();
            end
            #2;
            check($sformatf("%s_resolve", vecs[i].name), 32'(outs()),
                  32'({vecs[i].taken, vecs[i].taken, 2'b00, (vecs[i].stalls > 0)}));
            next_cycle();
            drive_idle();
            #2;
            check($sformatf("%s_idle", vecs[i].name), 32'(outs()), 32'(5'b00000));
`ifdef BRANCH_STATS_EN
            if (i == 2) begin
                check("stat_branches", bus.stat_branches, 32'd3);
                check("stat_taken", bus.stat_taken, 32'd2);
                check("stat_stall_cycles", bus.stat_stall_cycles, 32'd2);
            end
`endif
            next_cycle();
        end

        // Reset during STALL: outputs drop at once and no flush follows release.
        drive(vecs[2]);
        next_cycle();
        #2;
        check("mid_stall_outs", 32'(outs()), 32'(5'b00111));
        rst_n = 1'b0;
        #1;
        check("mid_stall_reset", 32'(outs()), 32'(5'b00000));
        drive_idle();
        #2;
        rst_n = 1'b1;
        next_cycle();
        #2;
        check("after_stall_reset", 32'(outs()), 32'(5'b00000));
        next_cycle();

        // Reset during RESOLVE of a taken branch: the flush is suppressed.
        drive(vecs[3]);
        next_cycle();
        #2;
        check("resolve_outs", 32'(outs()), 32'(5'b11001));
        rst_n = 1'b0;
        #1;
        check("mid_resolve_reset", 32'(outs()), 32'(5'b00000));
        drive_idle();
        #2;
        rst_n = 1'b1;
        next_cycle();
        #2;
        check("after_resolve_reset", 32'(outs()), 32'(5'b00000));
`ifdef BRANCH_STATS_EN
        check("stat_cleared", bus.stat_branches, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
